count_monitor: RTL
==================

// Module: count_monitor
// PURPOSE
//  Downstream checker/logger for the wrapping event counter (counts 0..MAX_COUNT, then back to 0).
//  Samples the counter value every clock and detects wrap events and sequence errors.
//  Timestamps each event and queues it in a small FIFO.
//  Events drain to the consumer over a valid/ready stream. FIFO overflow is counted, not stalled.
// PARAMETERS
//  CW        16  width of monitored count (matches counter CW)
//  MAX_COUNT 10  terminal count of the monitored counter
//  TW        16  timestamp width; free-running, wraps mod 2^TW
//  DEPTH     4   event FIFO depth; power of 2, >=2
// PORTS
//  i_clk         in   1          single clock
//  i_rst_n       in   1          reset, synchronous, active-low
//  i_count       in   CW         counter output sampled each cycle
//  i_count_rst   in   1          reset driven to the counter this cycle (expected resync)
//  o_valid       out  1          event available
//  i_ready       in   1          consumer accepts event when o_valid&&i_ready
//  o_event_type  out  2          01=WRAP, 10=SEQ_ERROR (00/11 never emitted)
//  o_event_time  out  TW         timestamp of the sample that raised the event
//  o_fill        out  log2(DEPTH)+1  events currently queued
//  o_drop_cnt    out  8          events lost to full FIFO, saturates at 255
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): o_valid=0, o_event_type=0, o_event_time=0, o_fill=0,
//   o_drop_cnt=0, timestamp=0, FIFO pointers=0, FSM->UNSYNC. Applies mid-operation; queued events are lost.
//  Timestamp ts: 0 in first cycle after reset release, +1 every cycle, wraps to 0.
//  FSM UNSYNC: no comparison. Capture prev=i_count, then go to TRACK.
//  FSM TRACK: expected = (prev==MAX_COUNT) ? 0 : prev+1 (CW-bit compare).
//   - prev==MAX_COUNT && i_count==0              -> push WRAP
//   - i_count!=expected                          -> push SEQ_ERROR
//   - otherwise no event. prev<=i_count every cycle.
//  Resync: i_count_rst=1 in cycle N -> sample in N+1 is not compared (skip flag), no event;
//   FSM stays TRACK, prev<=sample of N+1. Sample in N is still compared normally.
//  At most one event per cycle. WRAP takes priority (it also satisfies expected).
//  Latency: event raised by sample in cycle N is written at end of N; o_valid=1 from cycle N+1
//   if the FIFO was empty. FIFO is first-word-fall-through, outputs driven from registers.
//  Handshake: while o_valid && !i_ready, o_event_type and o_event_time hold stable.
//   Pop occurs on o_valid&&i_ready. i_ready is ignored when o_valid=0.
//  Full: push and pop in the same cycle both succeed (fill unchanged, no drop).
//   Push without pop when fill==DEPTH -> event discarded, o_drop_cnt+1 (saturates at 255).
//  Empty: pop impossible (o_valid=0). Push and pop on a 1-entry FIFO -> fill stays 1.
//  o_fill updates in the cycle after the push/pop edge. Pointers wrap mod DEPTH.
// TESTING
//  1 Reset release, i_count 0,1..10,0 (t=0..11), i_ready=1 -> one WRAP, time=11,
//    o_valid high only at t=12; no SEQ_ERROR.
//  2 TRACK, i_count ...,3,5 (5 at t=20) -> SEQ_ERROR, time=20, o_valid at t=21;
//    next sample 6 -> no event.
//  3 i_count_rst=1 while i_count=6, next sample 0 -> no event; following 1 -> no event.
//  4 i_ready=0, 5 wraps, DEPTH=4 -> o_fill=4, o_drop_cnt=1, head holds first WRAP time;
//    i_ready=1 -> 4 events drain in order, o_fill reaches 0.
//  5 FIFO full, event raised in the same cycle as an accepted pop -> o_fill stays 4,
//    o_drop_cnt unchanged.
//  6 i_rst_n=0 for 1 cycle with o_valid=1, fill=3 -> next cycle o_valid=0, o_fill=0,
//    o_drop_cnt=0, ts restarts at 0, first sample after release not compared.

Source files
------------

// File: rtl/count_monitor.sv
// Checks a wrapping counter stream, timestamps wrap and sequence-error events,
// and queues them in a small first-word-fall-through FIFO with drop counting.
module count_monitor #(
    parameter int CW        = 16,
    parameter int MAX_COUNT = 10,
    parameter int TW        = 16,
    parameter int DEPTH     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [CW-1:0]            i_count,
    input  logic                     i_count_rst,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [1:0]               o_event_type,
    output logic [TW-1:0]            o_event_time,
    output logic [$clog2(DEPTH):0]   o_fill,
    output logic [7:0]               o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] S_UNSYNC = 1'b0;
    localparam logic [0:0] S_TRACK  = 1'b1;

    localparam logic [1:0] EV_WRAP = 2'b01;
    localparam logic [1:0] EV_SEQ  = 2'b10;

    localparam logic [CW-1:0] MAXC = CW'(MAX_COUNT);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] prev_q;
    logic          skip_q;
    logic [TW-1:0] ts_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fill_q, fill_d;
    logic [7:0]    drop_q;

    logic [1:0]    mem_type_q [DEPTH];
    logic [TW-1:0] mem_time_q [DEPTH];

    logic [CW-1:0] exp_count;
    logic          evt_vld;
    logic [1:0]    evt_type;
    logic          push, pop, drop;

    always_comb begin
        state_d   = state_q;
        evt_vld   = 1'b0;
        evt_type  = EV_WRAP;
        exp_count = (prev_q == MAXC) ? '0 : prev_q + 1'b1;
        case (state_q)
            S_UNSYNC: state_d = S_TRACK;
            S_TRACK: begin
                // WRAP is checked first; it would also satisfy the expected value
                if (!skip_q) begin
                    if (prev_q == MAXC && i_count == '0) begin
                        evt_vld  = 1'b1;
                        evt_type = EV_WRAP;
                    end else if (i_count != exp_count) begin
                        evt_vld  = 1'b1;
                        evt_type = EV_SEQ;
                    end
                end
            end
            default: state_d = S_UNSYNC;
        endcase
    end

    assign o_valid = (fill_q != '0);
    assign pop     = o_valid & i_ready;
    assign push    = evt_vld & ((fill_q != FULL) | pop);
    assign drop    = evt_vld & (fill_q == FULL) & ~pop;

    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_UNSYNC;
            prev_q  <= '0;
            skip_q  <= 1'b0;
            ts_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= i_count;
            skip_q  <= i_count_rst;
            ts_q    <= ts_q + 1'b1;
            fill_q  <= fill_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_type_q[wr_q] <= evt_type;
            mem_time_q[wr_q] <= ts_q;
        end
    end

    assign o_event_type = o_valid ? mem_type_q[rd_q] : '0;
    assign o_event_time = o_valid ? mem_time_q[rd_q] : '0;
    assign o_fill       = fill_q;
    assign o_drop_cnt   = drop_q;

endmodule
